// File: rtl/aq_djpeg_pkg.sv
// rtl/aq_djpeg_pkg.sv - shared constants and types for the JPEG decoder bit path
// Marker codes, destuffer states and default stream widths.
package aq_djpeg_pkg;

   localparam int IN_W_DEF  = 32;
   localparam int WIN_W_DEF = 32;

   localparam logic [7:0] M_SOI  = 8'hD8;
   localparam logic [7:0] M_EOI  = 8'hD9;
   localparam logic [7:0] M_RST0 = 8'hD0;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_FF   = 2'd1,
      S_MARK = 2'd2,
      S_EOI  = 2'd3
   } ds_state_e;

endpackage

// File: rtl/aq_djpeg_destuff.sv
// rtl/aq_djpeg_destuff.sv - word-to-byte unpacker with 0xFF00 destuffing and marker capture
// Emits at most one byte per cycle; bytes that produce no output leave without waiting for byte_rdy.
module aq_djpeg_destuff
   import aq_djpeg_pkg::*;
#(
   parameter int IN_W = IN_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            scan_en,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [7:0]      byte_data,
   output logic            byte_vld,
   input  logic            byte_rdy,
   input  logic            mark_ack,
   output logic            in_mark,
   output logic            in_eoi,
   output logic [7:0]      mark_code
);

   localparam int NB = IN_W / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   logic [IN_W-1:0] hold_q, hold_d;
   logic            hold_vld_q, hold_vld_d;
   logic [IW-1:0]   idx_q, idx_d;
   ds_state_e       st_q, st_d;
   logic [7:0]      code_q, code_d;

   logic [IN_W-1:0] shifted;
   logic [7:0]      cur;
   logic            raw;
   logic            take;
   logic            last;

   always_comb begin
      shifted    = hold_q >> {idx_q, 3'b000};
      cur        = shifted[7:0];
      raw        = !scan_en && (st_q == S_RUN);
      byte_data  = cur;
      byte_vld   = 1'b0;
      take       = 1'b0;
      st_d       = st_q;
      code_d     = code_q;

      if (hold_vld_q) begin
         if (raw) begin
            byte_vld = 1'b1;
            take     = byte_rdy;
         end else if (st_q == S_RUN) begin
            if (cur == 8'hFF) begin
               take = 1'b1;
               st_d = S_FF;
            end else begin
               byte_vld = 1'b1;
               take     = byte_rdy;
            end
         end else if (st_q == S_FF) begin
            if (cur == 8'h00) begin
               byte_vld  = 1'b1;
               byte_data = 8'hFF;
               take      = byte_rdy;
               if (byte_rdy) begin
                  st_d = S_RUN;
               end
            end else if (cur == 8'hFF) begin
               // fill byte: keep waiting for the real second marker byte
               take = 1'b1;
            end else if (cur == M_EOI) begin
               take = 1'b1;
               st_d = S_EOI;
            end else begin
               take   = 1'b1;
               code_d = cur;
               st_d   = S_MARK;
            end
         end
      end

      if (st_q == S_MARK && mark_ack) begin
         st_d = S_RUN;
      end

      last     = take && (idx_q == IW'(NB - 1));
      in_ready = ((st_q == S_RUN) || (st_q == S_FF)) && (!hold_vld_q || last);

      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      idx_d      = idx_q;
      if (in_valid && in_ready) begin
         hold_d     = in_data;
         hold_vld_d = 1'b1;
         idx_d      = '0;
      end else if (take) begin
         if (last) begin
            hold_vld_d = 1'b0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end

      if (clear) begin
         hold_d     = '0;
         hold_vld_d = 1'b0;
         idx_d      = '0;
         st_d       = S_RUN;
         code_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         idx_q      <= '0;
         st_q       <= S_RUN;
         code_q     <= '0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         idx_q      <= idx_d;
         st_q       <= st_d;
         code_q     <= code_d;
      end
   end

   assign in_mark   = (st_q == S_MARK);
   assign in_eoi    = (st_q == S_EOI);
   assign mark_code = code_q;

endmodule

// File: rtl/aq_djpeg_bitbuf.sv
// rtl/aq_djpeg_bitbuf.sv - entropy-data bit buffer with MSB-first peek window
// The accumulator is MSB-aligned: bit BUF_W-1 is the oldest stream bit and bits past the fill are zero.
module aq_djpeg_bitbuf
   import aq_djpeg_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int WIN_W = WIN_W_DEF,
   parameter int BUF_W = 64,
   localparam int FW   = $clog2(BUF_W + 1),
   localparam int UW   = $clog2(WIN_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             scan_en,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIN_W-1:0] win_data,
   output logic [FW-1:0]    win_bits,
   output logic             win_valid,
   input  logic             use_en,
   input  logic [UW-1:0]    use_bits,
   input  logic             align_en,
   output logic             marker_valid,
   output logic [7:0]       marker_code,
   input  logic             marker_ack,
   output logic             rst_err,
   output logic             eoi,
   output logic             use_err
);

   logic [7:0] ds_byte;
   logic       ds_vld;
   logic       byte_rdy;
   logic       ds_mark;
   logic       ds_eoi;
   logic [7:0] ds_code;
   logic       ack_fire;

   logic [BUF_W-1:0] acc_q, acc_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             marker_valid_q, marker_valid_d;
   logic             rst_err_q, rst_err_d;
   logic             use_err_q, use_err_d;
   logic [2:0]       exp_idx_q, exp_idx_d;

   logic             stall;
   logic             over;
   logic             app;
   logic [FW-1:0]    use_amt;
   logic [FW-1:0]    after_use;
   logic [FW-1:0]    drop;
   logic [FW-1:0]    after_align;
   logic [FW-1:0]    sh;
   logic [BUF_W-1:0] acc_sh;
   logic [BUF_W-1:0] byte_top;

   assign ack_fire = marker_ack && marker_valid_q;
   assign byte_rdy = (fill_q <= FW'(BUF_W - 8));

   aq_djpeg_destuff #(
      .IN_W (IN_W)
   ) u_destuff (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .scan_en   (scan_en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .byte_data (ds_byte),
      .byte_vld  (ds_vld),
      .byte_rdy  (byte_rdy),
      .mark_ack  (ack_fire),
      .in_mark   (ds_mark),
      .in_eoi    (ds_eoi),
      .mark_code (ds_code)
   );

   always_comb begin
      stall       = ds_mark || ds_eoi;
      use_amt     = use_en ? FW'(use_bits) : '0;
      over        = (use_amt > fill_q);
      after_use   = over ? '0 : (fill_q - use_amt);
      drop        = align_en ? FW'(after_use[2:0]) : '0;
      after_align = after_use - drop;
      // shifting by the clamped use keeps the zero tail intact when use overruns the fill
      sh          = (over ? fill_q : use_amt) + drop;
      acc_sh      = acc_q << sh;
      app         = ds_vld && byte_rdy;
      byte_top    = {ds_byte, {(BUF_W - 8){1'b0}}};

      acc_d          = app ? (acc_sh | (byte_top >> after_align)) : acc_sh;
      fill_d         = after_align + (app ? FW'(8) : '0);
      rst_err_d      = rst_err_q;
      use_err_d      = use_err_q || (use_en && (FW'(use_bits) > fill_q) && !stall);
      exp_idx_d      = exp_idx_q;
      marker_valid_d = ds_mark && !ack_fire && (fill_q < FW'(8));

      if (ack_fire) begin
         acc_d     = '0;
         fill_d    = '0;
         rst_err_d = rst_err_q || (ds_code != (M_RST0 + {5'b00000, exp_idx_q}));
         exp_idx_d = ds_code[2:0] + 3'd1;
      end

      if (clear) begin
         acc_d          = '0;
         fill_d         = '0;
         rst_err_d      = 1'b0;
         use_err_d      = 1'b0;
         exp_idx_d      = '0;
         marker_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q          <= '0;
         fill_q         <= '0;
         marker_valid_q <= 1'b0;
         rst_err_q      <= 1'b0;
         use_err_q      <= 1'b0;
         exp_idx_q      <= '0;
      end else begin
         acc_q          <= acc_d;
         fill_q         <= fill_d;
         marker_valid_q <= marker_valid_d;
         rst_err_q      <= rst_err_d;
         use_err_q      <= use_err_d;
         exp_idx_q      <= exp_idx_d;
      end
   end

   assign win_data     = acc_q[BUF_W-1 -: WIN_W];
   assign win_bits     = fill_q;
   assign win_valid    = (fill_q >= FW'(WIN_W)) || stall;
   assign marker_valid = marker_valid_q;
   assign marker_code  = ds_code;
   assign rst_err      = rst_err_q;
   assign eoi          = ds_eoi;
   assign use_err      = use_err_q;

endmodule

// File: tb/tb_aq_djpeg_bitbuf.sv
// tb/tb_aq_djpeg_bitbuf.sv - directed self-checking bench for aq_djpeg_bitbuf
module tb_aq_djpeg_bitbuf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        scan_en = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] win_data;
   logic [6:0]  win_bits;
   logic        win_valid;
   logic        use_en = 1'b0;
   logic [5:0]  use_bits = '0;
   logic        align_en = 1'b0;
   logic        marker_valid;
   logic [7:0]  marker_code;
   logic        marker_ack = 1'b0;
   logic        rst_err;
   logic        eoi;
   logic        use_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aq_djpeg_bitbuf dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .scan_en      (scan_en),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .win_data     (win_data),
      .win_bits     (win_bits),
      .win_valid    (win_valid),
      .use_en       (use_en),
      .use_bits     (use_bits),
      .align_en     (align_en),
      .marker_valid (marker_valid),
      .marker_code  (marker_code),
      .marker_ack   (marker_ack),
      .rst_err      (rst_err),
      .eoi          (eoi),
      .use_err      (use_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   task automatic consume(input logic [5:0] n, input logic al);
      use_en   = 1'b1;
      use_bits = n;
      align_en = al;
      cyc(1);
      use_en   = 1'b0;
      align_en = 1'b0;
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_win_data", win_data, 0);
      chk("rst_win_bits", win_bits, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_marker_valid", marker_valid, 0);
      chk("rst_marker_code", marker_code, 0);
      chk("rst_flags", {rst_err, eoi, use_err}, 0);

      // raw header bytes
      scan_en = 1'b0;
      send(32'h44332211);
      send(32'h88776655);
      chk("raw_win_data0", win_data, 32'h11223344);
      chk("raw_win_bits0", win_bits, 32);
      cyc(4);
      chk("raw_win_bits_full", win_bits, 64);
      chk("raw_win_valid", win_valid, 1);
      consume(6'd32, 1'b0);
      chk("raw_win_data1", win_data, 32'h55667788);
      chk("raw_win_bits1", win_bits, 32);
      consume(6'd32, 1'b0);
      chk("raw_empty_valid", win_valid, 0);

      // stuffing
      pulse_clear();
      scan_en = 1'b1;
      send(32'h3400FF12);
      cyc(4);
      chk("stuff_win_data", win_data, 32'h12FF3400);
      chk("stuff_win_bits", win_bits, 24);
      send(32'hAB00FFFF);
      cyc(4);
      chk("fill_ff_win_bits", win_bits, 40);
      chk("fill_ff_win_data", win_data, 32'h12FF34FF);
      consume(6'd32, 1'b0);
      chk("fill_ff_tail", win_data, 32'hAB000000);

      // FF split across words
      pulse_clear();
      send(32'hFF030201);
      send(32'h06050400);
      cyc(4);
      chk("split_win_data", win_data, 32'h010203FF);
      chk("split_win_bits", win_bits, 56);
      chk("split_no_marker", marker_valid, 0);

      // restart marker
      pulse_clear();
      send(32'h77D0FFA5);
      cyc(4);
      chk("rst_stall_bits", win_bits, 8);
      chk("rst_stall_valid", win_valid, 1);
      chk("rst_stall_in_ready", in_ready, 0);
      chk("rst_mv_early", marker_valid, 0);
      consume(6'd5, 1'b0);
      chk("rst_mv_lag", marker_valid, 0);
      chk("rst_bits_after_use", win_bits, 3);
      cyc(1);
      chk("rst_mv_set", marker_valid, 1);
      chk("rst_code", marker_code, 8'hD0);
      chk("rst_pad_data", win_data, 32'hA0000000);
      marker_ack = 1'b1;
      cyc(1);
      marker_ack = 1'b0;
      chk("ack_mv_clr", marker_valid, 0);
      chk("ack_fill0", win_bits, 0);
      chk("ack_no_err", rst_err, 0);
      cyc(1);
      chk("ack_next_bits", win_bits, 8);
      chk("ack_next_data", win_data, 32'h77000000);
      send(32'h2211D2FF);
      cyc(2);
      consume(6'd8, 1'b0);
      cyc(1);
      chk("rst2_mv", marker_valid, 1);
      chk("rst2_code", marker_code, 8'hD2);
      marker_ack = 1'b1;
      cyc(1);
      marker_ack = 1'b0;
      chk("rst2_err", rst_err, 1);
      chk("rst2_mv_clr", marker_valid, 0);

      // EOI
      pulse_clear();
      send(32'h00D9FF7F);
      cyc(4);
      chk("eoi_flag", eoi, 1);
      chk("eoi_in_ready", in_ready, 0);
      chk("eoi_win_valid", win_valid, 1);
      chk("eoi_win_bits", win_bits, 8);
      chk("eoi_win_data", win_data, 32'h7F000000);
      pulse_clear();
      chk("clr_eoi", eoi, 0);
      chk("clr_in_ready", in_ready, 1);
      chk("clr_win", {win_data, 1'b0, win_bits, win_valid}, 0);
      chk("clr_marker", {marker_valid, marker_code}, 0);
      chk("clr_rst_err", rst_err, 0);

      // underflow
      consume(6'd4, 1'b0);
      chk("uerr_flag", use_err, 1);
      chk("uerr_floor", win_bits, 0);
      pulse_clear();
      chk("uerr_clr", use_err, 0);

      // use + align + append in one cycle
      scan_en = 1'b0;
      send(32'h04030201);
      send(32'h08070605);
      cyc(1);
      chk("arith_pre_bits", win_bits, 40);
      consume(6'd3, 1'b1);
      chk("arith_bits", win_bits, 40);
      chk("arith_data", win_data, 32'h02030405);
      chk("arith_no_uerr", use_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aq_djpeg_bitbuf.md
# aq_djpeg_bitbuf

Parametrised entropy-data bit buffer for the JPEG decoder. Sits between the input stream port and the Huffman/header decoders. It unpacks input words into bytes and, in scan mode, removes 0xFF00 byte stuffing and 0xFFFF fill bytes. It reports markers (RSTn with sequence check, EOI) and presents an MSB-first peek window that consumers drain by a variable bit count, with byte-align support.

## Interface
- IN_W, 32: input word width; multiple of 8, 8..64. Byte 0 (first in stream) is in_data[7:0].
- WIN_W, 32: peek window width, 16..32.
- BUF_W, 64: accumulator depth in bits; must be ≥ WIN_W+8, multiple of 8.
- FW = $clog2(BUF_W+1), UW = $clog2(WIN_W+1): derived widths.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of all state to reset values.
- scan_en  in  1  1 = entropy-coded data (destuff and detect markers); 0 = header bytes passed raw.
- in_data  in  IN_W  input word.
- in_valid  in  1  word valid.
- in_ready  out  1  word accepted on valid&ready.
- win_data  out  WIN_W  next WIN_W stream bits, MSB = oldest; bits beyond fill read 0.
- win_bits  out  FW  accumulator fill count.
- win_valid  out  1  fill ≥ WIN_W, or a marker/EOI stall is pending (zero padding).
- use_en  in  1  consume use_bits this cycle.
- use_bits  in  UW  bits to consume, 1..WIN_W.
- align_en  in  1  discard bits to the next byte boundary.
- marker_valid  out  1  RSTn reached and accumulator drained to < 8 bits.
- marker_code  out  8  second marker byte (D0..D7).
- marker_ack  in  1  accept marker and resume.
- rst_err  out  1  sticky: RSTn index ≠ expected.
- eoi  out  1  sticky: FFD9 seen in scan mode.
- use_err  out  1  sticky: use_bits > win_bits while not stalled.

## Operation
- Holding register with one word and byte index. in_ready = !hold_vld | (last byte leaves this cycle, no stall). in_ready = 0 in S_MARK/S_EOI.
- Destuffer handles one byte per cycle and appends it to the accumulator only when fill ≤ BUF_W−8. Otherwise the byte is held.
- Destuffer FSM (scan_en=1):
  - S_RUN: byte ≠ FF → append; FF → S_FF (nothing appended).
  - S_FF: 00 → append FF, go S_RUN; FF → stay S_FF (fill byte dropped); D0..D7 → latch code, S_MARK; D9 → S_EOI, eoi=1; other → latch code, S_MARK.
  - S_MARK: no appends. marker_valid=1 once fill < 8. On marker_ack:
    - fill ← 0 (padding discarded).
    - If code ≠ D0+exp_idx, set rst_err.
    - exp_idx ← code[2:0]+1 mod 8.
    - Go S_RUN.
  - S_EOI: no appends, no input accepted, until clear or reset.
  - The FF-pending state survives word boundaries.
- scan_en=0: every byte is appended raw and the FSM stays S_RUN. Changing scan_en only takes effect in S_RUN.
- Fill arithmetic, same cycle: fill' = align(fill − (use_en?use_bits:0)) + (append?8:0).
  - align(x) = x & ~7 when align_en, else x.
  - use_bits > fill: use_err set, fill floors at 0.
- exp_idx resets to 0 and is also zeroed by clear.

## Timing
- Reset/clear values:
  - in_ready=1, win_data=0, win_bits=0, win_valid=0.
  - marker_valid=0, marker_code=0, rst_err=0, eoi=0, use_err=0.
  - FSM=S_RUN, exp_idx=0.
- Word accepted at edge k: byte i is appended at edge k+1+i (no stall). It is visible on win_* after that edge.
- Outputs derive from registers only, with no combinational path from inputs except in_ready.
- use_en/align_en affect win_* after the same edge.
- marker_valid rises the cycle after fill drops below 8 in S_MARK. It falls the cycle after marker_ack.
- Back-to-back words with in_valid held high give a sustained 8 bits/cycle.
- rst asserted mid-word drops the held word and any pending FF.

## Structure
- Shared package aq_djpeg_pkg:
  - marker constants M_SOI=D8, M_EOI=D9, M_RST0=D0.
  - destuffer state enum.
  - IN_W/WIN_W defaults.
- Sub-module aq_djpeg_destuff: holding register, byte index, FF FSM and marker latch. It outputs byte + byte_vld, with byte_rdy from the accumulator.
- Top: accumulator, fill arithmetic, window slice, error flags.

## Test plan
- Raw: scan_en=0, words 0x44332211, 0x88776655 → win_data=0x11223344 at fill 32, then 0x55667788 after use 32.
- Stuffing: scan bytes 12 FF 00 34 → win_data[31:8]=0x12FF34, win_bits=24; FF FF 00 → single FF.
- Split FF: FF as the last byte of word n, 00 as the first byte of word n+1 → one FF appended, no marker.
- Restart: data A5, FF D0, use 5 → after draining, marker_valid=1, code=D0; ack → fill=0, next byte appended. A following FF D2 → rst_err=1.
- EOI: bytes 7F FF D9 → eoi=1, in_ready=0, win_valid=1 with zero padding; clear → all reset values.
- Arithmetic: fill 40, use_en 3 + align_en + append same cycle → fill 40.
